// File: rtl/branch_pkg.sv
// Shared encodings and helpers for ID-stage branch resolution.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTZ = 3'd4,
    BGEZ = 3'd5,
    BLEZ = 3'd6,
    BGTZ = 3'd7
  } br_op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } br_state_t;

  // Only the two-operand compares read rt; the zero-compares ignore it.
  function automatic logic uses_rt(input logic [2:0] op);
    return br_op_t'(op) inside {BEQ, BNE, BLT, BGE};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Signed branch-condition evaluator for all eight branch types.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              take
);

  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic                     aNeg;
  logic                     aZero;

  always_comb begin
    sa    = a;
    sb    = b;
    aNeg  = a[DATA_W-1];
    aZero = (a == '0);
    take  = 1'b0;
    case (br_op_t'(op))
      BEQ:     take = (a == b);
      BNE:     take = (a != b);
      BLT:     take = (sa < sb);
      BGE:     take = (sa >= sb);
      BLTZ:    take = aNeg;
      BGEZ:    take = !aNeg;
      BLEZ:    take = aNeg || aZero;
      BGTZ:    take = !aNeg && !aZero;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution with MEM forwarding, load/ALU hazard stalls and stats.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_d,
  input  logic [2:0]        br_op_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic              reg_write_e,
  input  logic              mem_to_reg_e,
  input  logic [REG_AW-1:0] write_reg_e,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [REG_AW-1:0] write_reg_m,
  input  logic [DATA_W-1:0] alu_out_m,
  output logic              pc_src_d,
  output logic              stall_fd,
  output logic              flush_e,
  output logic              flush_d,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  br_state_t         state;
  logic [1:0]        cnt;
  logic              useRt, exMatch, memMatch, fwdA, fwdB;
  logic [1:0]        depth;
  logic [DATA_W-1:0] opA, opB;
  logic              take, stallNow, resolveNow;

  always_comb begin
    useRt    = uses_rt(br_op_d);
    exMatch  = reg_write_e && (write_reg_e != '0) &&
               ((write_reg_e == rs_d) || (useRt && (write_reg_e == rt_d)));
    memMatch = reg_write_m && (write_reg_m != '0) &&
               ((write_reg_m == rs_d) || (useRt && (write_reg_m == rt_d)));

    if (exMatch && mem_to_reg_e)      depth = 2'd2;
    else if (exMatch)                 depth = 2'd1;
    else if (memMatch && mem_to_reg_m) depth = 2'd1;
    else                              depth = 2'd0;

    fwdA = reg_write_m && !mem_to_reg_m && (write_reg_m != '0) && (write_reg_m == rs_d);
    fwdB = reg_write_m && !mem_to_reg_m && (write_reg_m != '0) && (write_reg_m == rt_d);
    opA  = fwdA ? alu_out_m : rd1_d;
    opB  = fwdB ? alu_out_m : rd2_d;

    // Reset gates the combinational outputs so they drop the instant reset rises.
    stallNow   = !reset && ((state == STALL) || (branch_d && (depth != 2'd0)));
    resolveNow = !reset && (state == IDLE) && branch_d && (depth == 2'd0);
  end

  branch_cond_eval #(.DATA_W(DATA_W)) condEval (
    .op   (br_op_d),
    .a    (opA),
    .b    (opB),
    .take (take)
  );

  assign stall_fd = stallNow;
  assign flush_e  = stallNow;
  assign pc_src_d = resolveNow && take;
  assign flush_d  = resolveNow && take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_d && (depth == 2'd2)) begin
            state <= STALL;
            cnt   <= 2'd1;
          end
        end
        STALL: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (resolveNow && (branch_cnt != '1))          branch_cnt <= branch_cnt + 1'b1;
      if (resolveNow && take && (taken_cnt != '1))   taken_cnt  <= taken_cnt + 1'b1;
      if (stallNow && (stall_cnt != '1))             stall_cnt  <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle-level reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_d;
  logic [2:0]  br_op_d;
  logic [4:0]  rs_d, rt_d, write_reg_e, write_reg_m;
  logic [31:0] rd1_d, rd2_d, alu_out_m;
  logic        reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m;

  logic        pc_src_d, stall_fd, flush_e, flush_d;
  logic [15:0] branch_cnt, taken_cnt, stall_cnt;
  logic        pc2, stall2, flushE2, flushD2;
  logic [1:0]  branchCnt2, takenCnt2, stallCnt2;

  int checks = 0;
  int errors = 0;

  int mRem = 0;
  int mBr = 0;
  int mTk = 0;
  int mSt = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .branch_d(branch_d), .br_op_d(br_op_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .write_reg_e(write_reg_e),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .write_reg_m(write_reg_m),
    .alu_out_m(alu_out_m),
    .pc_src_d(pc_src_d), .stall_fd(stall_fd), .flush_e(flush_e), .flush_d(flush_d),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );

  branch_resolve_unit #(.DATA_W(32), .REG_AW(5), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .branch_d(branch_d), .br_op_d(br_op_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .write_reg_e(write_reg_e),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m), .write_reg_m(write_reg_m),
    .alu_out_m(alu_out_m),
    .pc_src_d(pc2), .stall_fd(stall2), .flush_e(flushE2), .flush_d(flushD2),
    .branch_cnt(branchCnt2), .taken_cnt(takenCnt2), .stall_cnt(stallCnt2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit mCond(input int op, input int a, input int b);
    case (op)
      0: return a == b;
      1: return a != b;
      2: return a < b;
      3: return a >= b;
      4: return a < 0;
      5: return a >= 0;
      6: return a <= 0;
      default: return a > 0;
    endcase
  endfunction

  function automatic int mDepth();
    bit rtUsed, ex, mem;
    rtUsed = (br_op_d < 3'd4);
    ex  = reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || (rtUsed && write_reg_e == rt_d));
    mem = reg_write_m && write_reg_m != 0 && (write_reg_m == rs_d || (rtUsed && write_reg_m == rt_d));
    if (ex && mem_to_reg_e) return 2;
    if (ex) return 1;
    if (mem && mem_to_reg_m) return 1;
    return 0;
  endfunction

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: every falling edge, predict this cycle's outputs from the inputs.
  always @(negedge clk) begin
    bit eStall, ePc, resolved, aluFwd;
    int n, a, b;
    eStall = 0; ePc = 0; resolved = 0;
    if (reset) begin
      mRem = 0; mBr = 0; mTk = 0; mSt = 0;
    end else if (mRem > 0) begin
      eStall = 1;
      mRem--;
    end else if (branch_d) begin
      n = mDepth();
      if (n > 0) begin
        eStall = 1;
        mRem = n - 1;
      end else begin
        aluFwd = reg_write_m && !mem_to_reg_m && write_reg_m != 0;
        a = (aluFwd && write_reg_m == rs_d) ? int'(alu_out_m) : int'(rd1_d);
        b = (aluFwd && write_reg_m == rt_d) ? int'(alu_out_m) : int'(rd2_d);
        ePc = mCond(int'(br_op_d), a, b);
        resolved = 1;
      end
    end
    check("pc_src_d", {31'd0, pc_src_d}, {31'd0, ePc});
    check("flush_d", {31'd0, flush_d}, {31'd0, ePc});
    check("stall_fd", {31'd0, stall_fd}, {31'd0, eStall});
    check("flush_e", {31'd0, flush_e}, {31'd0, eStall});
    check("branch_cnt", {16'd0, branch_cnt}, minInt(mBr, 65535));
    check("taken_cnt", {16'd0, taken_cnt}, minInt(mTk, 65535));
    check("stall_cnt", {16'd0, stall_cnt}, minInt(mSt, 65535));
    check("branch_cnt_w2", {30'd0, branchCnt2}, minInt(mBr, 3));
    check("taken_cnt_w2", {30'd0, takenCnt2}, minInt(mTk, 3));
    check("stall_cnt_w2", {30'd0, stallCnt2}, minInt(mSt, 3));
    if (!reset) begin
      if (eStall) mSt++;
      if (resolved) mBr++;
      if (resolved && ePc) mTk++;
    end
  end

  task automatic clearIn();
    branch_d = 0; br_op_d = 3'd0; rs_d = 5'd0; rt_d = 5'd0;
    rd1_d = 32'd0; rd2_d = 32'd0; alu_out_m = 32'd0;
    reg_write_e = 0; mem_to_reg_e = 0; write_reg_e = 5'd0;
    reg_write_m = 0; mem_to_reg_m = 0; write_reg_m = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vals [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  initial begin
    clearIn();
    // Inputs that would stall or resolve must be ignored while reset is high.
    branch_d = 1; br_op_d = 3'd0; rs_d = 5'd9; rt_d = 5'd9;
    reg_write_e = 1; mem_to_reg_e = 1; write_reg_e = 5'd9;
    step();
    #2;
    check("rst_stall", {31'd0, stall_fd}, 32'd0);
    check("rst_flush_e", {31'd0, flush_e}, 32'd0);
    check("rst_pc_src", {31'd0, pc_src_d}, 32'd0);
    step();
    check("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    clearIn();
    reset = 0;

    // No hazard, BEQ equal
    branch_d = 1; br_op_d = 3'd0; rs_d = 5'd1; rt_d = 5'd2; rd1_d = 32'h5; rd2_d = 32'h5;
    #2;
    check("t1_pc_src", {31'd0, pc_src_d}, 32'd1);
    check("t1_flush_d", {31'd0, flush_d}, 32'd1);
    check("t1_stall", {31'd0, stall_fd}, 32'd0);
    step();
    check("t1_branch_cnt", {16'd0, branch_cnt}, 32'd1);
    check("t1_taken_cnt", {16'd0, taken_cnt}, 32'd1);
    check("t1_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // ALU producer in EX, then forwarded from MEM
    clearIn();
    branch_d = 1; br_op_d = 3'd1; rs_d = 5'd8; rt_d = 5'd2; rd1_d = 32'h77; rd2_d = 32'h3;
    reg_write_e = 1; write_reg_e = 5'd8;
    #2;
    check("t2_stall", {31'd0, stall_fd}, 32'd1);
    check("t2_flush_e", {31'd0, flush_e}, 32'd1);
    check("t2_pc_src_stalled", {31'd0, pc_src_d}, 32'd0);
    step();
    reg_write_e = 0; write_reg_e = 5'd0;
    reg_write_m = 1; write_reg_m = 5'd8; alu_out_m = 32'h3;
    #2;
    check("t2_stall_after", {31'd0, stall_fd}, 32'd0);
    check("t2_pc_src", {31'd0, pc_src_d}, 32'd0);
    step();
    check("t2_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    check("t2_branch_cnt", {16'd0, branch_cnt}, 32'd2);

    // Load in EX: two stall cycles, then resolve
    clearIn();
    branch_d = 1; br_op_d = 3'd4; rs_d = 5'd9; rd1_d = 32'h0;
    reg_write_e = 1; mem_to_reg_e = 1; write_reg_e = 5'd9;
    #2;
    check("t3_stall_c1", {31'd0, stall_fd}, 32'd1);
    step();
    reg_write_e = 0; mem_to_reg_e = 0; write_reg_e = 5'd0;
    reg_write_m = 1; mem_to_reg_m = 1; write_reg_m = 5'd9;
    #2;
    check("t3_stall_c2", {31'd0, stall_fd}, 32'd1);
    check("t3_pc_src_c2", {31'd0, pc_src_d}, 32'd0);
    step();
    reg_write_m = 0; mem_to_reg_m = 0; write_reg_m = 5'd0; rd1_d = 32'hFFFF_FFFF;
    #2;
    check("t3_stall_c3", {31'd0, stall_fd}, 32'd0);
    check("t3_pc_src", {31'd0, pc_src_d}, 32'd1);
    step();
    check("t3_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    check("t3_taken_cnt", {16'd0, taken_cnt}, 32'd2);

    // rs=$0 and an EX producer on the unused rt
    clearIn();
    branch_d = 1; br_op_d = 3'd7; rs_d = 5'd0; rt_d = 5'd4;
    reg_write_e = 1; mem_to_reg_e = 1; write_reg_e = 5'd4;
    #2;
    check("t4_stall", {31'd0, stall_fd}, 32'd0);
    check("t4_pc_src", {31'd0, pc_src_d}, 32'd0);
    step();
    check("t4_branch_cnt", {16'd0, branch_cnt}, 32'd4);

    // MEM ALU forward on rt only: -5 < 2 taken (stale -10 would not be)
    clearIn();
    branch_d = 1; br_op_d = 3'd2; rs_d = 5'd3; rt_d = 5'd6;
    rd1_d = 32'hFFFF_FFFB; rd2_d = 32'hFFFF_FFF6;
    reg_write_m = 1; write_reg_m = 5'd6; alu_out_m = 32'h2;
    #2;
    check("t6_pc_src", {31'd0, pc_src_d}, 32'd1);
    step();

    // EX and MEM both write rs: EX hazard wins, then forward
    clearIn();
    branch_d = 1; br_op_d = 3'd0; rs_d = 5'd5; rt_d = 5'd5; rd1_d = 32'h1; rd2_d = 32'h1;
    reg_write_e = 1; write_reg_e = 5'd5;
    reg_write_m = 1; write_reg_m = 5'd5; alu_out_m = 32'h9;
    #2;
    check("t7_stall", {31'd0, stall_fd}, 32'd1);
    check("t7_pc_src_stalled", {31'd0, pc_src_d}, 32'd0);
    step();
    reg_write_e = 0; write_reg_e = 5'd0; alu_out_m = 32'h7;
    #2;
    check("t7_pc_src", {31'd0, pc_src_d}, 32'd1);
    step();

    // Non-branch with a load hazard never stalls
    clearIn();
    rs_d = 5'd9; reg_write_e = 1; mem_to_reg_e = 1; write_reg_e = 5'd9;
    #2;
    check("t8_nobranch_stall", {31'd0, stall_fd}, 32'd0);
    step();

    // Mixed branches without producers, checked by the model
    clearIn();
    for (int i = 0; i < 24; i++) begin
      branch_d = ($urandom_range(0, 3) != 0);
      br_op_d  = 3'($urandom_range(0, 7));
      rs_d     = 5'($urandom_range(1, 31));
      rt_d     = 5'($urandom_range(1, 31));
      rd1_d    = vals[$urandom_range(0, 4)];
      rd2_d    = vals[$urandom_range(0, 4)];
      step();
    end

    // Reset during the STALL cycle of a load-use branch
    clearIn();
    branch_d = 1; br_op_d = 3'd5; rs_d = 5'd9;
    reg_write_e = 1; mem_to_reg_e = 1; write_reg_e = 5'd9;
    step();
    #2;
    check("t5_in_stall", {31'd0, stall_fd}, 32'd1);
    reset = 1;
    #1;
    check("t5_rst_stall", {31'd0, stall_fd}, 32'd0);
    check("t5_rst_flush_e", {31'd0, flush_e}, 32'd0);
    check("t5_rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check("t5_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("t5_rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    step();
    clearIn();
    #2;
    reset = 0;
    step();
    #2;
    check("t5_post_stall", {31'd0, stall_fd}, 32'd0);
    step();

    // Saturation of the 2-bit instance
    reset = 1;
    step();
    #2;
    reset = 0;
    step();
    branch_d = 1; br_op_d = 3'd0; rs_d = 5'd1; rt_d = 5'd2; rd1_d = 32'h4; rd2_d = 32'h4;
    repeat (5) step();
    clearIn();
    check("sat_taken_w2", {30'd0, takenCnt2}, 32'd3);
    check("sat_branch_w2", {30'd0, branchCnt2}, 32'd3);
    check("sat_stall_w2", {30'd0, stallCnt2}, 32'd0);
    check("sat_taken_w16", {16'd0, taken_cnt}, 32'd5);
    check("sat_branch_w16", {16'd0, branch_cnt}, 32'd5);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
